// File: rtl/cascadable_mod_counter.sv
// Parametrised modulo-MODULUS counter with load, clear, enp/ent enables and a
// combinational ripple carry for cascading. Define CNT_UPDOWN_EN to add the up/down input.
module cascadable_mod_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 10,
  parameter int unsigned     WRAPW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
`ifdef CNT_UPDOWN_EN
  input  logic             up,
`endif
  input  logic             wrap_clr,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             tc_pulse,
  output logic [WRAPW-1:0] wrap_cnt
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("cascadable_mod_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("cascadable_mod_counter: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_pulse_q, tc_pulse_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             up_mode;
  logic             tc;
  logic             count_en;
  logic             wrap_event;
  logic [WIDTH-1:0] cnt_next;

`ifdef CNT_UPDOWN_EN
  assign up_mode = up;
`else
  assign up_mode = 1'b1;
`endif

  always_comb begin
    tc         = 1'b0;
    count_en   = enp & ent;
    wrap_event = 1'b0;
    cnt_next   = q_q;
    q_d        = q_q;
    wrap_cnt_d = wrap_cnt_q;

    if (up_mode) begin
      tc       = (q_q == TOP);
      // Anything at or above the top value (including out-of-range loads) returns to 0.
      cnt_next = (q_q >= TOP) ? '0 : q_q + WIDTH'(1);
    end else begin
      tc = (q_q == '0);
      if (q_q == '0 || q_q > TOP) begin
        cnt_next = TOP;
      end else begin
        cnt_next = q_q - WIDTH'(1);
      end
    end

    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end else if (count_en) begin
      q_d        = cnt_next;
      wrap_event = tc;
    end

    tc_pulse_d = wrap_event;

    if (wrap_clr) begin
      wrap_cnt_d = '0;
    end else if (wrap_event && wrap_cnt_q != {WRAPW{1'b1}}) begin
      wrap_cnt_d = wrap_cnt_q + WRAPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      tc_pulse_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      q_q        <= q_d;
      tc_pulse_q <= tc_pulse_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  // Carry is deliberately unregistered so a cascaded stage sees it on the same edge.
  assign rco      = ent & tc;
  assign q        = q_q;
  assign tc_pulse = tc_pulse_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_cascadable_mod_counter.sv
// Randomised bench for cascadable_mod_counter: a single counter (MODULUS=10, WRAPW=2)
// plus a two-digit decimal cascade, both checked against an arithmetic reference model.
module tb_cascadable_mod_counter;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int WW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, ld, enp, ent, wrap_clr;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          rco, tc_pulse;
  logic [WW-1:0] wrap_cnt;
`ifdef CNT_UPDOWN_EN
  logic          up_i;
`endif

  logic          cas_en;
  logic [W-1:0]  lo_q, hi_q;
  logic          lo_rco, hi_rco, lo_tc, hi_tc;
  logic [7:0]    lo_wc, hi_wc;

  cascadable_mod_counter #(.WIDTH(W), .MODULUS(M), .WRAPW(WW)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .enp(enp), .ent(ent),
`ifdef CNT_UPDOWN_EN
    .up(up_i),
`endif
    .wrap_clr(wrap_clr), .q(q), .rco(rco), .tc_pulse(tc_pulse), .wrap_cnt(wrap_cnt)
  );

  cascadable_mod_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
    .clk(clk), .rst(rst), .clr(1'b0), .ld(1'b0), .d('0), .enp(1'b1), .ent(cas_en),
`ifdef CNT_UPDOWN_EN
    .up(1'b1),
`endif
    .wrap_clr(1'b0), .q(lo_q), .rco(lo_rco), .tc_pulse(lo_tc), .wrap_cnt(lo_wc)
  );

  cascadable_mod_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
    .clk(clk), .rst(rst), .clr(1'b0), .ld(1'b0), .d('0), .enp(1'b1), .ent(lo_rco),
`ifdef CNT_UPDOWN_EN
    .up(1'b1),
`endif
    .wrap_clr(1'b0), .q(hi_q), .rco(hi_rco), .tc_pulse(hi_tc), .wrap_cnt(hi_wc)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: single counter value, pulse, wrap count; cascade as a 0..99 value.
  int mq = 0, mpulse = 0, mwrap = 0, mcas = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit up_now;
    bit wrap;
    up_now = 1'b1;
`ifdef CNT_UPDOWN_EN
    up_now = up_i;
`endif
    @(posedge clk);
    wrap = 1'b0;
    if (rst) begin
      mq = 0; mpulse = 0; mwrap = 0; mcas = 0;
    end else begin
      if (clr) mq = 0;
      else if (ld) mq = int'(d);
      else if (enp && ent) begin
        if (up_now) begin
          if (mq == M - 1) begin wrap = 1'b1; mq = 0; end
          else if (mq > M - 1) mq = 0;
          else mq = mq + 1;
        end else begin
          if (mq == 0) begin wrap = 1'b1; mq = M - 1; end
          else if (mq > M - 1) mq = M - 1;
          else mq = mq - 1;
        end
      end
      mpulse = int'(wrap);
      if (wrap_clr) mwrap = 0;
      else if (wrap && mwrap < (1 << WW) - 1) mwrap = mwrap + 1;
      if (cas_en) mcas = (mcas + 1) % 100;
    end
    #1;
    check("q", 64'(q), 64'(mq));
    check("tc_pulse", 64'(tc_pulse), 64'(mpulse));
    check("wrap_cnt", 64'(wrap_cnt), 64'(mwrap));
    check("rco", 64'(rco), 64'(ent && (up_now ? (mq == M - 1) : (mq == 0))));
    check("cas_lo", 64'(lo_q), 64'(mcas % 10));
    check("cas_hi", 64'(hi_q), 64'(mcas / 10));
    check("cas_carry", 64'(hi_rco), 64'(cas_en && mcas == 99));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; enp = 1'b0; ent = 1'b0;
    wrap_clr = 1'b0; d = '0; cas_en = 1'b0;
`ifdef CNT_UPDOWN_EN
    up_i = 1'b1;
`endif

    // Reset for two cycles, then count twelve edges.
    step(); step();
    check("reset_q", 64'(q), 64'd0);
    rst = 1'b0; enp = 1'b1; ent = 1'b1; cas_en = 1'b1;
    repeat (12) step();
    check("plan_wrap_once", 64'(wrap_cnt), 64'd1);
    $display("[TB] count phase q=%0d wrap_cnt=%0d", q, wrap_cnt);

    // Priority: clr beats ld, ld alone loads, enp=0 holds.
    ld = 1'b1; d = 4'd5; step();
    clr = 1'b1; d = 4'd7; step();
    check("prio_clr", 64'(q), 64'd0);
    clr = 1'b0; step();
    ld = 1'b0; enp = 1'b0; step();
    check("prio_hold", 64'(q), 64'd7);
    check("prio_rco", 64'(rco), 64'd0);

    // Out-of-range load recovers to 0 without a wrap event.
    ld = 1'b1; d = 4'd13; step();
    ld = 1'b0; enp = 1'b1; step();
    check("oor_q", 64'(q), 64'd0);
    check("oor_pulse", 64'(tc_pulse), 64'd0);

    // Saturation of the 2-bit wrap counter after five wraps.
    wrap_clr = 1'b1; step(); wrap_clr = 1'b0;
    repeat (50) step();
    check("sat_wrap", 64'(wrap_cnt), 64'd3);

    // wrap_clr coinciding with a wrap event wins.
    ld = 1'b1; d = 4'd9; step(); ld = 1'b0;
    wrap_clr = 1'b1; step(); wrap_clr = 1'b0;
    check("clr_vs_wrap_cnt", 64'(wrap_cnt), 64'd0);
    check("clr_vs_wrap_pulse", 64'(tc_pulse), 64'd1);

    // Reset on a would-be wrapping edge drops the pulse.
    ld = 1'b1; d = 4'd9; step(); ld = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_q", 64'(q), 64'd0);
    check("midrst_pulse", 64'(tc_pulse), 64'd0);

`ifdef CNT_UPDOWN_EN
    // Down counting from 2 through the 0 -> 9 wrap, then out-of-range recovery.
    ld = 1'b1; d = 4'd2; step(); ld = 1'b0;
    up_i = 1'b0;
    step(); check("dn_1", 64'(q), 64'd1);
    step(); check("dn_0", 64'(q), 64'd0);
    step(); check("dn_9", 64'(q), 64'd9);
    check("dn_pulse", 64'(tc_pulse), 64'd1);
    step(); check("dn_8", 64'(q), 64'd8);
    ld = 1'b1; d = 4'd12; step(); ld = 1'b0;
    step(); check("dn_oor", 64'(q), 64'd9);
    up_i = 1'b1;
`endif

    // Full cascade sweep through 99 -> 00.
    rst = 1'b1; step(); rst = 1'b0; cas_en = 1'b1;
    repeat (105) step();
    check("cas_after_105", 64'(hi_q * 10 + lo_q), 64'd5);
    $display("[TB] cascade phase value=%0d%0d", hi_q, lo_q);

    // Randomised mix of all controls.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      clr      = ($urandom_range(0, 19) == 0);
      ld       = ($urandom_range(0, 9) == 0);
      d        = W'($urandom_range(0, 15));
      enp      = ($urandom_range(0, 4) != 0);
      ent      = ($urandom_range(0, 4) != 0);
      wrap_clr = ($urandom_range(0, 29) == 0);
      cas_en   = ($urandom_range(0, 3) != 0);
`ifdef CNT_UPDOWN_EN
      up_i     = ($urandom_range(0, 1) == 1);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
